sram_chip_model: RTL and testbench
==================================

Name: sram_chip_model

Overview:
- Synthesizable behavioural model of the 16-bit external SRAM device: the responder end of the SRAM_DQ / SRAM_ADDR / SRAM_WE_N bus driven by the team's SRAM controller.
- Used in the system testbench and the FPGA loopback build in place of the physical chip.
- Stores writes on the clock edge and returns reads after a configurable latency.
- Provides write statistics and an out-of-range flag for checking.

Parameters:
- DATA_W, 16, data bus width.
- ADDR_W, 18, SRAM address width.
- DEPTH, 1024, number of implemented words; must be a power of two and at most 2**ADDR_W.
- READ_LAT, 0, clock edges from address sampled to DQ valid; legal range 0..4. 0 means asynchronous-read chip.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- SRAM_DQ  inout  DATA_W  bidirectional data; the model drives it only on reads.
- SRAM_ADDR  in  ADDR_W  word address from the controller.
- SRAM_WE_N  in  1  write enable, active low. High means read.
- wr_count  out  16  number of write cycles since reset; wraps at 0xFFFF to 0.
- addr_oob  out  1  sticky flag: an address at or above DEPTH was presented while active.

Behaviour:
- Reset (asynchronous, active high):
  - Takes effect immediately.
  - Pipeline valid bits cleared, wr_count=0, addr_oob=0.
  - SRAM_DQ released to Z for the whole time rst is high.
  - Memory array is NOT reset: contents survive reset.
  - Reset during an active read drops the in-flight data; nothing is driven afterwards until the pipeline refills.
- Indexing:
  - Index = SRAM_ADDR[log2(DEPTH)-1:0]. Upper bits alias.
  - If SRAM_ADDR >= DEPTH on a write cycle or a sampled read cycle, addr_oob is set at that edge and held until reset.
- Write:
  - At each posedge with rst low and SRAM_WE_N=0: mem[index] <= SRAM_DQ and wr_count increments.
  - Consecutive low cycles are independent writes. A write to a new address every cycle is legal.
- Read, READ_LAT=0:
  - While SRAM_WE_N=1 and rst=0, SRAM_DQ = mem[index(SRAM_ADDR)] combinationally.
  - A controller that updates the address at edge N samples the data at edge N+1.
- Read, READ_LAT=L>=1:
  - Each posedge with SRAM_WE_N=1 pushes {valid=1, index} into an L-deep delay line.
  - An edge with SRAM_WE_N=0 pushes valid=0.
  - The array is read at the pipeline output, so the data reflects any write that completed before the output stage.
  - SRAM_DQ = data of the last stage when that stage is valid AND SRAM_WE_N=1; otherwise Z.
  - Fully pipelined: back-to-back reads return one word per cycle.
- Bus turnaround:
  - The model never drives while SRAM_WE_N=0. Release is combinational on the falling edge of WE_N, so there is no contention with controller write data.
  - After WE_N returns high, DQ stays Z for L cycles (0 cycles when L=0).
- Simultaneous events:
  - Write and read of the same index at the same edge (L>=1): the read stage issued earlier returns the value from after the write.
  - Any X/Z on DQ during a write is stored as-is in simulation.
- Width rules:
  - wr_count is an unsigned 16-bit wrapping counter.
  - No byte enables; every access is a full 16-bit word.

Decomposition:
- Shared package holds:
  - SRAM_DATA_W=16 and SRAM_ADDR_W=18, also used by the controller.
  - The constant SRAM_MAX_READ_LAT=4.
- Natural sub-module: sram_rd_pipe.
  - Parameterized delay line of {valid, index} with depth READ_LAT and asynchronous reset of the valid bits.
  - Generates a pass-through when READ_LAT=0.
- Array, write logic, counters and the tristate driver stay in the top module.

Test Plan:
1. L=0: reset, WE_N=0 addr 5 DQ=0xBEEF for one edge, then WE_N=1 addr 5 -> DQ=0xBEEF in the same cycle; wr_count=1; addr_oob=0.
2. L=0, 32-bit controller pattern: write 0x5678@0x10 and 0x1234@0x11, then read 0x10 and 0x11 on consecutive cycles -> 0x5678 then 0x1234; wr_count=2.
3. L=2: preload 1:0xA1, 2:0xB2, 3:0xC3; read addresses 1,2,3 on back-to-back edges -> DQ=0xA1,0xB2,0xC3 on the 2nd,3rd,4th cycles after the first address; Z before that.
4. L=1 turnaround: during a read stream drop WE_N -> DQ is Z in the same cycle. Raise WE_N -> Z for 1 cycle, then valid data; never both sides driving.
5. DEPTH=1024: write 0x077 at addr 0x400 -> read addr 0 returns 0x0077; addr_oob=1 and stays 1 through further in-range accesses until rst.
6. L=2: assert rst for 1 cycle with a read in flight -> DQ goes Z immediately, no stale beat afterwards, wr_count=0; a re-read of a previously written address still returns the old data.

Source files
------------

// File: rtl/sram_chip_model_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_chip_model_pkg
//  Purpose  : Shared SRAM bus constants and types (controller and chip model).
//  Revision : 1.0
// ============================================================================
package sram_chip_model_pkg;

    localparam int SRAM_DATA_W       = 16;
    localparam int SRAM_ADDR_W       = 18;
    localparam int SRAM_MAX_READ_LAT = 4;

    // SRAM_WE_N level directly encodes the bus operation
    typedef enum logic [0:0] {
        SRAM_OP_WRITE = 1'b0,
        SRAM_OP_READ  = 1'b1
    } sram_op_e;

    function automatic int sram_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sram_rd_pipe
//  Purpose  : {valid, index} read delay line of depth LAT; wire-through at 0.
//  Revision : 1.0
// ============================================================================
module sram_rd_pipe
    import sram_chip_model_pkg::*;
#(
    parameter int LAT   = 0,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    localparam int c_LAT = (LAT > SRAM_MAX_READ_LAT) ? SRAM_MAX_READ_LAT : LAT;

    generate
        if (c_LAT == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
            assign o_valid = i_valid;
            assign o_idx   = i_idx;
        end else begin : g_pipe
            logic             r_valid [c_LAT];
            logic [IDX_W-1:0] r_idx   [c_LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < c_LAT; i++) r_valid[i] <= 1'b0;
                end else begin
                    r_valid[0] <= i_valid;
                    for (int i = 1; i < c_LAT; i++) r_valid[i] <= r_valid[i-1];
                end
            end

            // Indices are qualified by the valid bits, so they need no reset
            always_ff @(posedge clk) begin
                r_idx[0] <= i_idx;
                for (int i = 1; i < c_LAT; i++) r_idx[i] <= r_idx[i-1];
            end

            assign o_valid = r_valid[c_LAT-1];
            assign o_idx   = r_idx[c_LAT-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sram_chip_model.sv
`default_nettype none
// ============================================================================
//  Module   : sram_chip_model
//  Purpose  : Behavioural 16-bit SRAM responder with configurable read latency.
//  Revision : 1.0
// ============================================================================
module sram_chip_model
    import sram_chip_model_pkg::*;
#(
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_WE_N,
    output logic [15:0]       wr_count,
    output logic              addr_oob
);

    localparam int IDX_W = sram_idx_w(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [15:0]       r_wr_count;
    logic              r_addr_oob;

    logic              w_is_read;
    logic              w_wr_en;
    logic              w_oob;
    logic [IDX_W-1:0]  w_idx;
    logic              w_pipe_valid;
    logic [IDX_W-1:0]  w_pipe_idx;
    logic              w_dq_oe;

    assign w_is_read = (sram_op_e'(SRAM_WE_N) == SRAM_OP_READ);
    assign w_wr_en   = !w_is_read && !rst;
    assign w_idx     = SRAM_ADDR[IDX_W-1:0];
    assign w_oob     = {1'b0, SRAM_ADDR} >= (ADDR_W+1)'(DEPTH);

    sram_rd_pipe #(
        .LAT   (READ_LAT),
        .IDX_W (IDX_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_is_read),
        .i_idx   (w_idx),
        .o_valid (w_pipe_valid),
        .o_idx   (w_pipe_idx)
    );

    // Array contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_idx] <= SRAM_DQ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_count <= 16'd0;
            r_addr_oob <= 1'b0;
        end else begin
            if (!w_is_read) r_wr_count <= r_wr_count + 16'd1;
            if (w_oob)      r_addr_oob <= 1'b1;
        end
    end

    // Array read at the pipe output so completed writes are always visible;
    // gating on WE_N releases the bus the instant the controller starts a write
    assign w_dq_oe = w_pipe_valid && w_is_read && !rst;
    assign SRAM_DQ = w_dq_oe ? r_mem[w_pipe_idx] : {DATA_W{1'bz}};

    assign wr_count = r_wr_count;
    assign addr_oob = r_addr_oob;

endmodule
`default_nettype wire

// File: tb/tb_sram_chip_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_chip_model
//  Purpose  : Scoreboard bench for sram_chip_model at READ_LAT 0, 1 and 2.
//  Revision : 1.0
// ============================================================================
module tb_sram_chip_model;

    localparam int K_DQ  = 0;
    localparam int K_REL = 1;
    localparam int K_CNT = 2;
    localparam int K_OOB = 3;

    typedef struct {
        int          cyc;
        int          dut;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          checks;
    int          failures;
    exp_t        sb [$];

    logic [17:0] addr  [3];
    logic        we_n  [3];
    logic        drv   [3];
    logic [15:0] wdat  [3];

    wire  [15:0] dq0, dq1, dq2;
    wire  [15:0] cnt0, cnt1, cnt2;
    wire         oob0, oob1, oob2;

    assign dq0 = drv[0] ? wdat[0] : 16'hzzzz;
    assign dq1 = drv[1] ? wdat[1] : 16'hzzzz;
    assign dq2 = drv[2] ? wdat[2] : 16'hzzzz;

    sram_chip_model #(.DATA_W(16), .ADDR_W(18), .DEPTH(1024), .READ_LAT(0)) u_l0 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq0), .SRAM_ADDR(addr[0]),
        .SRAM_WE_N(we_n[0]), .wr_count(cnt0), .addr_oob(oob0));
    sram_chip_model #(.DATA_W(16), .ADDR_W(18), .DEPTH(1024), .READ_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr[1]),
        .SRAM_WE_N(we_n[1]), .wr_count(cnt1), .addr_oob(oob1));
    sram_chip_model #(.DATA_W(16), .ADDR_W(18), .DEPTH(1024), .READ_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_ADDR(addr[2]),
        .SRAM_WE_N(we_n[2]), .wr_count(cnt2), .addr_oob(oob2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] get_dq(input int k);
        case (k)
            0:       return dq0;
            1:       return dq1;
            default: return dq2;
        endcase
    endfunction

    function automatic logic [15:0] get_cnt(input int k);
        case (k)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction

    function automatic logic get_oob(input int k);
        case (k)
            0:       return oob0;
            1:       return oob1;
            default: return oob2;
        endcase
    endfunction

    // An undriven net reads Z in four-state simulators and 0 in two-state
    // ones; all data written by this bench is non-zero.
    function automatic bit released(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    task automatic check(input exp_t e);
        logic [15:0] act;
        bit          bad;
        checks++;
        case (e.kind)
            K_DQ:    begin act = get_dq(e.dut);  bad = (act !== e.val); end
            K_REL:   begin act = get_dq(e.dut);  bad = !released(act); end
            K_CNT:   begin act = get_cnt(e.dut); bad = (act !== e.val); end
            default: begin act = {15'd0, get_oob(e.dut)}; bad = (act !== e.val); end
        endcase
        if (bad) begin
            failures++;
            if (e.kind == K_REL)
                $display("FAIL %s dut%0d cyc%0d: got %h, required released bus", e.name, e.dut, cyc, act);
            else
                $display("FAIL %s dut%0d cyc%0d: got %h, required %h", e.name, e.dut, cyc, act, e.val);
        end
    endtask

    // Monitor: sample mid-cycle, retire every expectation due this cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i]);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int k, input int kind, input logic [15:0] v,
                             input int offs, input string name);
        exp_t e;
        e.cyc = cyc + offs; e.dut = k; e.kind = kind; e.val = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input logic [17:0] a, input logic [15:0] d);
        we_n[k] = 1'b0; drv[k] = 1'b1; wdat[k] = d; addr[k] = a;
    endtask

    task automatic rd(input int k, input logic [17:0] a);
        we_n[k] = 1'b1; drv[k] = 1'b0; addr[k] = a;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            we_n[k] = 1'b1; drv[k] = 1'b0; wdat[k] = 16'h0; addr[k] = 18'h0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            expect_at(k, K_REL, 16'h0, 0, "reset_dq");
            expect_at(k, K_CNT, 16'h0, 0, "reset_cnt");
            expect_at(k, K_OOB, 16'h0, 0, "reset_oob");
        end
        tick();
        rst = 1'b0;

        // L=0: write then same-cycle combinational read
        wr(0, 18'h5, 16'hBEEF);
        tick();
        rd(0, 18'h5);
        expect_at(0, K_DQ,  16'hBEEF, 0, "l0_read_beef");
        expect_at(0, K_CNT, 16'd1,    0, "l0_cnt1");
        expect_at(0, K_OOB, 16'h0,    0, "l0_oob0");
        tick();

        // L=0: two-word controller pattern
        wr(0, 18'h10, 16'h5678); tick();
        wr(0, 18'h11, 16'h1234); tick();
        rd(0, 18'h10);
        expect_at(0, K_DQ, 16'h5678, 0, "l0_lo_word");
        tick();
        rd(0, 18'h11);
        expect_at(0, K_DQ,  16'h1234, 0, "l0_hi_word");
        expect_at(0, K_CNT, 16'd3,    0, "l0_cnt3");
        tick();

        // Out-of-range write aliases onto index 0 and sets the sticky flag
        wr(0, 18'h400, 16'h0077);
        expect_at(0, K_OOB, 16'h0, 0, "oob_before_edge");
        tick();
        rd(0, 18'h0);
        expect_at(0, K_DQ,  16'h0077, 0, "alias_read");
        expect_at(0, K_OOB, 16'h1,    0, "oob_set");
        tick();
        rd(0, 18'h10);
        expect_at(0, K_DQ,  16'h5678, 0, "alias_other_intact");
        expect_at(0, K_OOB, 16'h1,    0, "oob_sticky1");
        tick();
        wr(0, 18'h20, 16'h0CAB); tick();
        rd(0, 18'h0);
        expect_at(0, K_OOB, 16'h1, 0, "oob_sticky2");
        tick();

        // L=1 turnaround
        wr(1, 18'h7, 16'h1111); tick();
        wr(1, 18'h8, 16'h2222); tick();
        rd(1, 18'h7);
        expect_at(1, K_REL, 16'h0, 0, "l1_gap_after_write");
        tick();
        rd(1, 18'h8);
        expect_at(1, K_DQ, 16'h1111, 0, "l1_read7");
        tick();
        we_n[1] = 1'b0; addr[1] = 18'h9;
        expect_at(1, K_REL, 16'h0, 0, "l1_release_on_we");
        #5;
        drv[1] = 1'b1; wdat[1] = 16'h3333;
        tick();
        rd(1, 18'h9);
        expect_at(1, K_REL, 16'h0, 0, "l1_turnaround_gap");
        tick();
        expect_at(1, K_DQ,  16'h3333, 0, "l1_read9");
        expect_at(1, K_CNT, 16'd3,    0, "l1_cnt3");
        tick();

        // L=2 pipelined reads
        wr(2, 18'h1, 16'h00A1); tick();
        wr(2, 18'h2, 16'h00B2); tick();
        wr(2, 18'h3, 16'h00C3); tick();
        rd(2, 18'h1);
        expect_at(2, K_REL, 16'h0,    0, "l2_lat_gap0");
        expect_at(2, K_DQ,  16'h00A1, 2, "l2_beat_a1");
        tick();
        rd(2, 18'h2);
        expect_at(2, K_REL, 16'h0,    0, "l2_lat_gap1");
        expect_at(2, K_DQ,  16'h00B2, 2, "l2_beat_b2");
        tick();
        rd(2, 18'h3);
        expect_at(2, K_DQ, 16'h00C3, 2, "l2_beat_c3");
        tick();
        rd(2, 18'h2);
        expect_at(2, K_DQ, 16'h00B2, 2, "l2_beat_b2_again");
        tick();
        tick();
        tick();

        // Reset with two reads in flight
        rst = 1'b1;
        expect_at(2, K_REL, 16'h0, 0, "l2_rst_release");
        expect_at(2, K_CNT, 16'h0, 0, "l2_rst_cnt");
        expect_at(1, K_CNT, 16'h0, 0, "l1_rst_cnt");
        expect_at(0, K_CNT, 16'h0, 0, "l0_rst_cnt");
        expect_at(0, K_OOB, 16'h0, 0, "oob_cleared");
        tick();
        rst = 1'b0;
        expect_at(2, K_REL, 16'h0,    0, "l2_no_stale0");
        expect_at(0, K_DQ,  16'h0077, 0, "l0_mem_survives");
        tick();
        expect_at(2, K_REL, 16'h0, 0, "l2_no_stale1");
        tick();
        expect_at(2, K_DQ, 16'h00B2, 0, "l2_mem_survives");
        tick();

        tick();
        tick();
        foreach (sb[i]) begin
            checks++;
            failures++;
            $display("FAIL %s dut%0d: expectation for cyc%0d never sampled", sb[i].name, sb[i].dut, sb[i].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
